branch_execute_unit: RTL and testbench



---
 rtl/rv_exec_pkg.sv | 25 ++
 rtl/branch_compare.sv | 46 ++++
 rtl/branch_execute_unit.sv | 163 ++++++++++++++++
 tb/tb_branch_execute_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_exec_pkg.sv
// Shared definitions for the execute-stage branch/ALU unit: the FSM state encoding,
// the op-flag priority indices, the default datapath width and the x0 register index.
package rv_exec_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam logic [4:0]  REG_X0       = 5'd0;

    // Op-flag bit positions in the packed op vector.
    // A lower index means a higher priority.
    localparam int unsigned OP_BEQ  = 0;
    localparam int unsigned OP_BNE  = 1;
    localparam int unsigned OP_BLT  = 2;
    localparam int unsigned OP_BGE  = 3;
    localparam int unsigned OP_BLTU = 4;
    localparam int unsigned OP_BGEU = 5;
    localparam int unsigned OP_ADDI = 6;
    localparam int unsigned OP_ADD  = 7;
    localparam int unsigned NUM_OPS = 8;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_e;

endpackage

// File: rtl/branch_compare.sv
// Combinational branch condition evaluation.
// When several branch flags are set, the highest-priority flag decides the outcome:
// beq > bne > blt > bge > bltu > bgeu.
module branch_compare
    import rv_exec_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            beq,
    input  logic            bne,
    input  logic            blt,
    input  logic            bge,
    input  logic            bltu,
    input  logic            bgeu,
    output logic            taken
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rs1_data == rs2_data);
    assign lt_s = ($signed(rs1_data) < $signed(rs2_data));
    assign lt_u = (rs1_data < rs2_data);

    // Select the condition of the highest-priority asserted branch flag.
    always_comb begin
        taken = 1'b0;
        if (beq) begin
            taken = eq;
        end else if (bne) begin
            taken = !eq;
        end else if (blt) begin
            taken = lt_s;
        end else if (bge) begin
            taken = !lt_s;
        end else if (bltu) begin
            taken = lt_u;
        end else if (bgeu) begin
            taken = !lt_u;
        end
    end

endmodule

// File: rtl/branch_execute_unit.sv
// Execute stage: resolves branches, performs addi/add and issues writeback requests.
// All outputs are registered.
// A taken branch squashes the next FLUSH_DEPTH cycles of input, which are the
// wrong-path slots still in flight in the decoder.
// Optional macro BRANCH_STATS_EN adds saturating branch and taken-branch counters.
module branch_execute_unit
    import rv_exec_pkg::*;
#(
    parameter int unsigned FLUSH_DEPTH = 1,
    parameter int unsigned XLEN        = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            beq,
    input  logic            bne,
    input  logic            blt,
    input  logic            bge,
    input  logic            bltu,
    input  logic            bgeu,
    input  logic            addi,
    input  logic            add,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] ex_pc,
    output logic            jump_branch_enable,
    output logic [XLEN-1:0] jump_target,
    output logic            wb_enable,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     branch_count,
    output logic [31:0]     taken_count
`endif
);

    localparam logic [2:0] FLUSH_CNT = 3'(FLUSH_DEPTH);

    logic [NUM_OPS-1:0] ops;
    logic               is_branch;
    logic               taken;

    state_e             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;

    logic               jbe_d;
    logic [XLEN-1:0]    target_d;
    logic               wb_en_d;
    logic [4:0]         wb_rd_d;
    logic [XLEN-1:0]    wb_data_d;

    assign ops = {add, addi, bgeu, bltu, bge, blt, bne, beq};
    assign is_branch = |ops[OP_BGEU:OP_BEQ];

    branch_compare #(
        .XLEN (XLEN)
    ) u_branch_compare (
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .beq      (ops[OP_BEQ]),
        .bne      (ops[OP_BNE]),
        .blt      (ops[OP_BLT]),
        .bge      (ops[OP_BGE]),
        .bltu     (ops[OP_BLTU]),
        .bgeu     (ops[OP_BGEU]),
        .taken    (taken)
    );

    // Next-state and next-output decode for the RUN/SQUASH machine.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        jbe_d     = 1'b0;
        target_d  = '0;
        wb_en_d   = 1'b0;
        wb_rd_d   = REG_X0;
        wb_data_d = '0;
        unique case (state_q)
            ST_RUN: begin
                if (is_branch) begin
                    if (taken) begin
                        jbe_d    = 1'b1;
                        target_d = ex_pc + imm;
                        if (FLUSH_DEPTH != 0) begin
                            state_d = ST_SQUASH;
                            cnt_d   = FLUSH_CNT;
                        end
                    end
                end else if (ops[OP_ADDI]) begin
                    if (rd != REG_X0) begin
                        wb_en_d   = 1'b1;
                        wb_rd_d   = rd;
                        wb_data_d = rs1_data + imm;
                    end
                end else if (ops[OP_ADD]) begin
                    if (rd != REG_X0) begin
                        wb_en_d   = 1'b1;
                        wb_rd_d   = rd;
                        wb_data_d = rs1_data + rs2_data;
                    end
                end
            end
            ST_SQUASH: begin
                // Squash is counted per cycle: decode emits bubbles as all-zero flags.
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // State, squash counter and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q            <= ST_RUN;
            cnt_q              <= 3'd0;
            jump_branch_enable <= 1'b0;
            jump_target        <= '0;
            wb_enable          <= 1'b0;
            wb_rd              <= REG_X0;
            wb_data            <= '0;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            jump_branch_enable <= jbe_d;
            jump_target        <= target_d;
            wb_enable          <= wb_en_d;
            wb_rd              <= wb_rd_d;
            wb_data            <= wb_data_d;
        end
    end

`ifdef BRANCH_STATS_EN
    logic count_branch;
    logic count_taken;

    assign count_branch = (state_q == ST_RUN) && is_branch;
    assign count_taken  = count_branch && taken;

    // Saturating statistics counters; squashed slots are not counted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            branch_count <= '0;
            taken_count  <= '0;
        end else begin
            if (count_branch && (branch_count != 32'hFFFF_FFFF)) begin
                branch_count <= branch_count + 32'd1;
            end
            if (count_taken && (taken_count != 32'hFFFF_FFFF)) begin
                taken_count <= taken_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_execute_unit.sv
// Directed self-checking bench for branch_execute_unit.
// Uses the default FLUSH_DEPTH of 1, so each taken branch squashes exactly one cycle.
module tb_branch_execute_unit;

    localparam int XLEN = 32;

    logic            clk;
    logic            reset_n;
    logic            beq, bne, blt, bge, bltu, bgeu, addi, add;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm, rs1_data, rs2_data, ex_pc;
    logic            jump_branch_enable;
    logic [XLEN-1:0] jump_target;
    logic            wb_enable;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
`ifdef BRANCH_STATS_EN
    logic [31:0]     branch_count;
    logic [31:0]     taken_count;
`endif

    int tests;
    int fails;

    branch_execute_unit #(
        .FLUSH_DEPTH (1),
        .XLEN        (XLEN)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .beq                (beq),
        .bne                (bne),
        .blt                (blt),
        .bge                (bge),
        .bltu               (bltu),
        .bgeu               (bgeu),
        .addi               (addi),
        .add                (add),
        .rd                 (rd),
        .imm                (imm),
        .rs1_data           (rs1_data),
        .rs2_data           (rs2_data),
        .ex_pc              (ex_pc),
        .jump_branch_enable (jump_branch_enable),
        .jump_target        (jump_target),
        .wb_enable          (wb_enable),
        .wb_rd              (wb_rd),
        .wb_data            (wb_data)
`ifdef BRANCH_STATS_EN
        ,
        .branch_count       (branch_count),
        .taken_count        (taken_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ops order (MSB..LSB): add addi bgeu bltu bge blt bne beq
    task automatic set_in(input logic [7:0] ops, input logic [4:0] r, input logic [31:0] im,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
        {add, addi, bgeu, bltu, bge, blt, bne, beq} = ops;
        rd = r;
        imm = im;
        rs1_data = a;
        rs2_data = b;
        ex_pc = pc;
    endtask

    // Present one slot, then move to 1 time unit after the capturing edge.
    task automatic step(input logic [7:0] ops, input logic [4:0] r, input logic [31:0] im,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
        set_in(ops, r, im, a, b, pc);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(8'h40, 5'd9, 32'h5, 32'h7, 32'h1, 32'h0);
        step(8'h01, 5'd0, 32'h8, 32'h3, 32'h3, 32'h40);
        tests++;
        if (jump_branch_enable !== 1'b0 || jump_target !== 32'h0) begin
            fails++;
            $display("FAIL reset_jump: got jbe=%b tgt=%h, want 0/0", jump_branch_enable,
                     jump_target);
        end
        tests++;
        if (wb_enable !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'h0) begin
            fails++;
            $display("FAIL reset_wb: got en=%b rd=%0d data=%h, want 0/0/0", wb_enable, wb_rd,
                     wb_data);
        end
        reset_n = 1'b1;
        step(8'h00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_arith();
        step(8'h40, 5'd5, 32'hFFFF_FFFC, 32'h0000_0010, 32'h0, 32'h0);
        tests++;
        if (wb_enable !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'h0000_000C) begin
            fails++;
            $display("FAIL addi: got en=%b rd=%0d data=%h, want 1/5/0000000c", wb_enable, wb_rd,
                     wb_data);
        end
        step(8'h80, 5'd0, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0);
        tests++;
        if (wb_enable !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'h0) begin
            fails++;
            $display("FAIL add_x0: got en=%b rd=%0d data=%h, want 0/0/0", wb_enable, wb_rd,
                     wb_data);
        end
        step(8'h80, 5'd7, 32'h0, 32'hFFFF_FFFF, 32'h2, 32'h0);
        tests++;
        if (wb_enable !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 32'h1) begin
            fails++;
            $display("FAIL add_wrap: got en=%b rd=%0d data=%h, want 1/7/00000001", wb_enable,
                     wb_rd, wb_data);
        end
        // addi outranks add: 1 + 10, not 1 + 100.
        step(8'hC0, 5'd2, 32'd10, 32'd1, 32'd100, 32'h0);
        tests++;
        if (wb_enable !== 1'b1 || wb_data !== 32'd11) begin
            fails++;
            $display("FAIL prio_addi_add: got en=%b data=%h, want 1/0000000b", wb_enable, wb_data);
        end
        step(8'h00, 5'd3, 32'h0, 32'h5, 32'h6, 32'h0);
        tests++;
        if (wb_enable !== 1'b0 || wb_data !== 32'h0) begin
            fails++;
            $display("FAIL bubble: got en=%b data=%h, want 0/0", wb_enable, wb_data);
        end
    endtask

    task automatic test_branch();
        step(8'h04, 5'd0, 32'h20, 32'hFFFF_FFFF, 32'h1, 32'h100);
        tests++;
        if (jump_branch_enable !== 1'b1 || jump_target !== 32'h120 || wb_enable !== 1'b0) begin
            fails++;
            $display("FAIL blt_taken: got jbe=%b tgt=%h wb=%b, want 1/00000120/0",
                     jump_branch_enable, jump_target, wb_enable);
        end
        step(8'h00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        tests++;
        if (jump_branch_enable !== 1'b0 || jump_target !== 32'h0) begin
            fails++;
            $display("FAIL blt_one_cycle: got jbe=%b tgt=%h, want 0/0", jump_branch_enable,
                     jump_target);
        end
        step(8'h10, 5'd0, 32'h20, 32'hFFFF_FFFF, 32'h1, 32'h100);
        tests++;
        if (jump_branch_enable !== 1'b0 || jump_target !== 32'h0 || wb_enable !== 1'b0) begin
            fails++;
            $display("FAIL bltu_not_taken: got jbe=%b tgt=%h wb=%b, want 0/0/0",
                     jump_branch_enable, jump_target, wb_enable);
        end
        // bgeu taken with wrapping target: FFFFFFF0 + 20 = 10.
        step(8'h20, 5'd0, 32'h20, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFF0);
        tests++;
        if (jump_branch_enable !== 1'b1 || jump_target !== 32'h10) begin
            fails++;
            $display("FAIL bgeu_wrap: got jbe=%b tgt=%h, want 1/00000010", jump_branch_enable,
                     jump_target);
        end
        step(8'h00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        // beq (not taken) outranks bne (would be taken): nothing happens.
        step(8'h03, 5'd0, 32'h40, 32'h1, 32'h2, 32'h200);
        tests++;
        if (jump_branch_enable !== 1'b0 || jump_target !== 32'h0) begin
            fails++;
            $display("FAIL prio_beq_bne: got jbe=%b tgt=%h, want 0/0", jump_branch_enable,
                     jump_target);
        end
        // bge signed: -5 >= -6 taken, negative offset.
        step(8'h08, 5'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h300);
        tests++;
        if (jump_branch_enable !== 1'b1 || jump_target !== 32'h2F8) begin
            fails++;
            $display("FAIL bge_signed: got jbe=%b tgt=%h, want 1/000002f8", jump_branch_enable,
                     jump_target);
        end
        step(8'h00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_squash();
        step(8'h01, 5'd0, 32'h40, 32'h5, 32'h5, 32'h200);
        tests++;
        if (jump_branch_enable !== 1'b1 || jump_target !== 32'h240) begin
            fails++;
            $display("FAIL beq_taken: got jbe=%b tgt=%h, want 1/00000240", jump_branch_enable,
                     jump_target);
        end
        step(8'h80, 5'd3, 32'h0, 32'h1, 32'h2, 32'h204);
        tests++;
        if (wb_enable !== 1'b0 || wb_data !== 32'h0) begin
            fails++;
            $display("FAIL squash_add: got en=%b data=%h, want 0/0", wb_enable, wb_data);
        end
        step(8'h80, 5'd3, 32'h0, 32'h1, 32'h2, 32'h240);
        tests++;
        if (wb_enable !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'h3) begin
            fails++;
            $display("FAIL after_squash_add: got en=%b rd=%0d data=%h, want 1/3/00000003",
                     wb_enable, wb_rd, wb_data);
        end
        // A taken branch in the squash slot is ignored.
        step(8'h01, 5'd0, 32'h40, 32'h5, 32'h5, 32'h300);
        step(8'h01, 5'd0, 32'h80, 32'h5, 32'h5, 32'h304);
        tests++;
        if (jump_branch_enable !== 1'b0 || jump_target !== 32'h0) begin
            fails++;
            $display("FAIL squash_branch: got jbe=%b tgt=%h, want 0/0", jump_branch_enable,
                     jump_target);
        end
        step(8'h00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset_mid_squash();
        step(8'h02, 5'd0, 32'h10, 32'h1, 32'h2, 32'h400);
        tests++;
        if (jump_branch_enable !== 1'b1 || jump_target !== 32'h410) begin
            fails++;
            $display("FAIL bne_taken: got jbe=%b tgt=%h, want 1/00000410", jump_branch_enable,
                     jump_target);
        end
        set_in(8'h00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        reset_n = 1'b0;
        #1;
        tests++;
        if (jump_branch_enable !== 1'b0 || jump_target !== 32'h0 || wb_enable !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: got jbe=%b tgt=%h wb=%b, want 0/0/0",
                     jump_branch_enable, jump_target, wb_enable);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(8'h40, 5'd4, 32'h3, 32'h4, 32'h0, 32'h0);
        tests++;
        if (wb_enable !== 1'b1 || wb_rd !== 5'd4 || wb_data !== 32'h7) begin
            fails++;
            $display("FAIL post_reset_addi: got en=%b rd=%0d data=%h, want 1/4/00000007",
                     wb_enable, wb_rd, wb_data);
        end
        step(8'h00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats();
        reset_n = 1'b0;
        #1;
        tests++;
        if (branch_count !== 32'd0 || taken_count !== 32'd0) begin
            fails++;
            $display("FAIL stats_reset: got %0d/%0d, want 0/0", branch_count, taken_count);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(8'h01, 5'd0, 32'h8, 32'h1, 32'h1, 32'h0);
        step(8'h02, 5'd0, 32'h8, 32'h1, 32'h2, 32'h0);
        step(8'h02, 5'd0, 32'h8, 32'h1, 32'h1, 32'h0);
        step(8'h04, 5'd0, 32'h8, 32'hFFFF_FFFF, 32'h0, 32'h0);
        step(8'h00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        tests++;
        if (branch_count !== 32'd3 || taken_count !== 32'd2) begin
            fails++;
            $display("FAIL stats_counts: got %0d/%0d, want 3/2", branch_count, taken_count);
        end
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        set_in(8'h00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        reset_n = 1'b0;
        #2;
        test_reset();
        test_arith();
        test_branch();
        test_squash();
        test_reset_mid_squash();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
